// File: rtl/ysyx_22040895_memarb_pkg.sv
// Shared encodings and default widths for the memory-port arbiter.
// Pure declarations: no latency or backpressure of its own.
package ysyx_22040895_memarb_pkg;

  localparam int ADDR_W_DEF     = 64;
  localparam int DATA_W_DEF     = 64;
  localparam int MAX_STREAK_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // Counter must hold 0..max_streak inclusive.
  function automatic int streak_w(input int max_streak);
    int w;
    w = $clog2(max_streak + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ysyx_22040895_memarb_if.sv
// Bundle of IF, LS and external-memory handshake signals around the arbiter.
// slave = arbiter side, master = requesters plus memory (environment side).
interface ysyx_22040895_memarb_if
  import ysyx_22040895_memarb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic                  if_req_i;
  logic [ADDR_W-1:0]     if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [DATA_W-1:0]     if_rdata_o;

  logic                  ls_req_i;
  logic                  ls_we_i;
  logic [ADDR_W-1:0]     ls_addr_i;
  logic [DATA_W-1:0]     ls_wdata_i;
  logic [DATA_W/8-1:0]   ls_wmask_i;
  logic                  ls_gnt_o;
  logic                  ls_rvalid_o;
  logic [DATA_W-1:0]     ls_rdata_o;

  logic                  mem_req_o;
  logic                  mem_gnt_i;
  logic                  mem_we_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic [DATA_W/8-1:0]   mem_wmask_o;
  logic                  mem_rvalid_i;
  logic [DATA_W-1:0]     mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

endinterface

// File: rtl/ysyx_22040895_memarb_pick.sv
// Winner select (LS first, IF forced after MAX_STREAK LS wins) and streak update.
// Purely combinational; the result is only applied when a launch actually happens.
module ysyx_22040895_memarb_pick
  import ysyx_22040895_memarb_pkg::*;
#(
  parameter int MAX_STREAK = MAX_STREAK_DEF,
  parameter int SW         = streak_w(MAX_STREAK)
) (
  input  logic          if_req_i,
  input  logic          ls_req_i,
  input  logic [SW-1:0] streak_i,
  output owner_e        winner_o,
  output logic [SW-1:0] streak_next_o
);

  localparam logic [SW-1:0] LIMIT = SW'(MAX_STREAK);

  logic force_if;

  always_comb begin
    force_if      = if_req_i && (streak_i >= LIMIT);
    winner_o      = OWN_IF;
    streak_next_o = '0;
    if (ls_req_i && !force_if) begin
      winner_o = OWN_LS;
      // Streak only counts LS wins that actually kept IF waiting.
      if (if_req_i) begin
        streak_next_o = (streak_i >= LIMIT) ? LIMIT : streak_i + SW'(1);
      end
    end
  end

endmodule

// File: rtl/ysyx_22040895_memarb.sv
// Two-requester arbiter (IF, LS) onto one memory port, one transaction in flight.
// Registered request fields held until mem_gnt_i; gnt/rvalid routed combinationally to the owner.
module ysyx_22040895_memarb
  import ysyx_22040895_memarb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_STREAK = MAX_STREAK_DEF
) (
  input logic                   clk,
  input logic                   rst,
  ysyx_22040895_memarb_if.slave bus
);

  localparam int SW = streak_w(MAX_STREAK);
  localparam int MW = DATA_W / 8;

  state_e              state_q;
  owner_e              owner_q;
  owner_e              winner;
  logic [SW-1:0]       streak_q;
  logic [SW-1:0]       streak_d;
  logic                mem_req_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MW-1:0]       wmask_q;

  logic any_req;
  logic gnt_fire;
  logic resp_fire;
  logic launch;
  logic if_rv;
  logic ls_rv;

  ysyx_22040895_memarb_pick #(
    .MAX_STREAK (MAX_STREAK),
    .SW         (SW)
  ) u_pick (
    .if_req_i      (bus.if_req_i),
    .ls_req_i      (bus.ls_req_i),
    .streak_i      (streak_q),
    .winner_o      (winner),
    .streak_next_o (streak_d)
  );

  assign any_req   = bus.if_req_i | bus.ls_req_i;
  assign gnt_fire  = (state_q == ST_REQ) & bus.mem_gnt_i;
  assign resp_fire = (state_q == ST_RESP) & bus.mem_rvalid_i;
  // A completing response doubles as an arbitration point so a waiter issues back-to-back.
  assign launch    = any_req & ((state_q == ST_IDLE) | resp_fire);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IF;
      streak_q  <= '0;
      mem_req_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
    end else if (launch) begin
      state_q   <= ST_REQ;
      owner_q   <= winner;
      streak_q  <= streak_d;
      mem_req_q <= 1'b1;
      if (winner == OWN_LS) begin
        we_q    <= bus.ls_we_i;
        addr_q  <= bus.ls_addr_i;
        wdata_q <= bus.ls_wdata_i;
        wmask_q <= bus.ls_we_i ? bus.ls_wmask_i : '0;
      end else begin
        we_q    <= 1'b0;
        addr_q  <= bus.if_addr_i;
        wdata_q <= '0;
        wmask_q <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_IDLE;
        ST_REQ: begin
          if (bus.mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.mem_rvalid_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_rv = resp_fire & (owner_q == OWN_IF);
  assign ls_rv = resp_fire & (owner_q == OWN_LS);

  assign bus.if_gnt_o    = gnt_fire & (owner_q == OWN_IF);
  assign bus.ls_gnt_o    = gnt_fire & (owner_q == OWN_LS);
  assign bus.if_rvalid_o = if_rv;
  assign bus.ls_rvalid_o = ls_rv;
  assign bus.if_rdata_o  = if_rv ? bus.mem_rdata_i : '0;
  assign bus.ls_rdata_o  = (ls_rv & ~we_q) ? bus.mem_rdata_i : '0;

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_wmask_o = wmask_q;

endmodule

// File: tb/tb_ysyx_22040895_memarb.sv
// Directed bench for the memory arbiter: per-requester expectation queues filled when a
// request is raised, drained when the arbiter issues it to memory and returns its response.
module tb_ysyx_22040895_memarb;
  import ysyx_22040895_memarb_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
  } exp_t;

  exp_t if_q[$];
  exp_t ls_q[$];

  ysyx_22040895_memarb_if #(.ADDR_W(64), .DATA_W(64)) bus();

  ysyx_22040895_memarb #(
    .ADDR_W     (64),
    .DATA_W     (64),
    .MAX_STREAK (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] memfn(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h00000513_00100073;
    return {a[31:0], ~a[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_req"},   64'(bus.mem_req_o),   64'd0);
    chk({tag, "_mem_we"},    64'(bus.mem_we_o),    64'd0);
    chk({tag, "_mem_addr"},  bus.mem_addr_o,       64'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata_o,      64'd0);
    chk({tag, "_mem_wmask"}, 64'(bus.mem_wmask_o), 64'd0);
    chk({tag, "_if_gnt"},    64'(bus.if_gnt_o),    64'd0);
    chk({tag, "_ls_gnt"},    64'(bus.ls_gnt_o),    64'd0);
    chk({tag, "_if_rvalid"}, 64'(bus.if_rvalid_o), 64'd0);
    chk({tag, "_ls_rvalid"}, 64'(bus.ls_rvalid_o), 64'd0);
  endtask

  // Advance to just after the next rising edge and drop the one-cycle memory strobes.
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  task automatic req_if(input logic [63:0] a);
    exp_t e;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = a;
    e.we = 1'b0; e.addr = a; e.wdata = '0; e.wmask = '0; e.rdata = memfn(a);
    if_q.push_back(e);
  endtask

  task automatic req_ls(input logic we, input logic [63:0] a, input logic [63:0] wd, input logic [7:0] wm);
    exp_t e;
    bus.ls_req_i   = 1'b1;
    bus.ls_we_i    = we;
    bus.ls_addr_i  = a;
    bus.ls_wdata_i = wd;
    bus.ls_wmask_i = wm;
    e.we = we; e.addr = a; e.wdata = wd;
    e.wmask = we ? wm : 8'h00;
    e.rdata = we ? 64'd0 : memfn(a);
    ls_q.push_back(e);
  endtask

  // Play the memory for one transaction expected from 'own': gw stall cycles before gnt,
  // response rw cycles after gnt. Optionally re-raise LS with a new address right after its gnt.
  task automatic serve(input owner_e own, input int gw, input int rw, input bit rearm,
                       input logic [63:0] rearm_addr, output int waited);
    exp_t e;
    int   n;
    bit   fire;
    n = 0;
    cyc();
    #1;
    while (!bus.mem_req_o && n < 40) begin
      cyc();
      #1;
      n++;
    end
    waited = n;
    chk("issue_req", 64'(bus.mem_req_o), 64'd1);
    if ((own == OWN_IF && if_q.size() == 0) || (own == OWN_LS && ls_q.size() == 0)) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = (own == OWN_IF) ? if_q.pop_front() : ls_q.pop_front();
    for (int k = 0; k <= gw; k++) begin
      if (k > 0) cyc();
      if (k == gw) bus.mem_gnt_i = 1'b1;
      #1;
      fire = (k == gw);
      chk("req_hold",  64'(bus.mem_req_o),   64'd1);
      chk("mem_we",    64'(bus.mem_we_o),    64'(e.we));
      chk("mem_addr",  bus.mem_addr_o,       e.addr);
      chk("mem_wdata", bus.mem_wdata_o,      e.wdata);
      chk("mem_wmask", 64'(bus.mem_wmask_o), 64'(e.wmask));
      chk("if_gnt",    64'(bus.if_gnt_o),    64'(fire && own == OWN_IF));
      chk("ls_gnt",    64'(bus.ls_gnt_o),    64'(fire && own == OWN_LS));
    end
    for (int r = 1; r <= rw; r++) begin
      cyc();
      if (r == 1) begin
        if (own == OWN_IF) bus.if_req_i = 1'b0;
        else if (rearm) req_ls(bus.ls_we_i, rearm_addr, bus.ls_wdata_i, bus.ls_wmask_i);
        else bus.ls_req_i = 1'b0;
      end
      if (r == rw) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = memfn(bus.mem_addr_o);
      end
      #1;
      fire = (r == rw);
      chk("resp_req_low", 64'(bus.mem_req_o),   64'd0);
      chk("resp_if_gnt",  64'(bus.if_gnt_o),    64'd0);
      chk("resp_ls_gnt",  64'(bus.ls_gnt_o),    64'd0);
      chk("if_rvalid",    64'(bus.if_rvalid_o), 64'(fire && own == OWN_IF));
      chk("ls_rvalid",    64'(bus.ls_rvalid_o), 64'(fire && own == OWN_LS));
      chk("if_rdata",     bus.if_rdata_o, (fire && own == OWN_IF) ? e.rdata : 64'd0);
      chk("ls_rdata",     bus.ls_rdata_o, (fire && own == OWN_LS) ? e.rdata : 64'd0);
    end
  endtask

  initial begin
    int w;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.if_req_i = 1'b0; bus.if_addr_i = '0;
    bus.ls_req_i = 1'b0; bus.ls_we_i = 1'b0; bus.ls_addr_i = '0;
    bus.ls_wdata_i = '0; bus.ls_wmask_i = '0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;

    #3;
    chk_quiet("reset");
    @(negedge clk);
    rst = 1'b1;

    // IF alone
    cyc();
    req_if(64'h8000_0000);
    serve(OWN_IF, 1, 2, 1'b0, 64'd0, w);
    chk("if_alone_latency", 64'(w), 64'd0);

    // LS write
    cyc();
    req_ls(1'b1, 64'h8000_1008, 64'h0000_0000_DEAD_BEEF, 8'h0F);
    serve(OWN_LS, 1, 2, 1'b0, 64'd0, w);
    chk("ls_write_latency", 64'(w), 64'd0);

    // Simultaneous: LS first, IF issued straight out of the LS response cycle
    cyc();
    req_if(64'h8000_0004);
    req_ls(1'b0, 64'h8000_2000, 64'd0, 8'h00);
    serve(OWN_LS, 1, 1, 1'b0, 64'd0, w);
    chk("simul_ls_latency", 64'(w), 64'd0);
    serve(OWN_IF, 1, 2, 1'b0, 64'd0, w);
    chk("simul_if_back2back", 64'(w), 64'd0);

    // Stall: ten cycles without gnt, read mask forced to zero
    cyc();
    req_ls(1'b0, 64'h8000_4000, 64'h1234, 8'hFF);
    serve(OWN_LS, 10, 1, 1'b0, 64'd0, w);
    chk("stall_latency", 64'(w), 64'd0);

    // Starvation guard: four LS, forced IF, then LS resumes
    cyc();
    req_if(64'h8000_0100);
    req_ls(1'b0, 64'h8000_3000, 64'd0, 8'h00);
    serve(OWN_LS, 1, 1, 1'b1, 64'h8000_3008, w);
    chk("starve_ls1", 64'(w), 64'd0);
    serve(OWN_LS, 1, 1, 1'b1, 64'h8000_3010, w);
    chk("starve_ls2", 64'(w), 64'd0);
    serve(OWN_LS, 1, 1, 1'b1, 64'h8000_3018, w);
    chk("starve_ls3", 64'(w), 64'd0);
    serve(OWN_LS, 1, 1, 1'b1, 64'h8000_3020, w);
    chk("starve_ls4", 64'(w), 64'd0);
    serve(OWN_IF, 1, 1, 1'b0, 64'd0, w);
    chk("starve_if_forced", 64'(w), 64'd0);
    serve(OWN_LS, 1, 1, 1'b1, 64'h8000_3028, w);
    chk("starve_ls_resume", 64'(w), 64'd0);
    serve(OWN_LS, 1, 1, 1'b0, 64'd0, w);
    chk("starve_ls_last", 64'(w), 64'd0);

    // Reset between gnt and rvalid, then a stray response
    cyc();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 64'h8000_5000;
    cyc();
    #1;
    chk("rst_txn_req", 64'(bus.mem_req_o), 64'd1);
    cyc();
    bus.mem_gnt_i = 1'b1;
    #1;
    chk("rst_txn_gnt", 64'(bus.if_gnt_o), 64'd1);
    cyc();
    bus.if_req_i = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk_quiet("midresp_reset");
    @(negedge clk);
    rst = 1'b1;
    cyc();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    chk("stray_if_rvalid", 64'(bus.if_rvalid_o), 64'd0);
    chk("stray_ls_rvalid", 64'(bus.ls_rvalid_o), 64'd0);
    chk("stray_if_rdata",  bus.if_rdata_o,       64'd0);
    chk("stray_ls_rdata",  bus.ls_rdata_o,       64'd0);
    cyc();
    #1;
    chk("post_rst_idle_req", 64'(bus.mem_req_o), 64'd0);
    req_if(64'h8000_6000);
    serve(OWN_IF, 1, 2, 1'b0, 64'd0, w);
    chk("post_rst_latency", 64'(w), 64'd0);
    chk("if_queue_drained", 64'(if_q.size()), 64'd0);
    chk("ls_queue_drained", 64'(ls_q.size()), 64'd0);

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
